// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timer controller: register map, counter width
// and count-direction encoding.
package pwm_pkg;

    localparam int CNT_W = 16;

    localparam logic [5:0] ADDR_PERIOD_L      = 6'h00;
    localparam logic [5:0] ADDR_PERIOD_H      = 6'h01;
    localparam logic [5:0] ADDR_COUNTER_EN    = 6'h02;
    localparam logic [5:0] ADDR_COMPARE1_L    = 6'h03;
    localparam logic [5:0] ADDR_COMPARE1_H    = 6'h04;
    localparam logic [5:0] ADDR_COMPARE2_L    = 6'h05;
    localparam logic [5:0] ADDR_COMPARE2_H    = 6'h06;
    localparam logic [5:0] ADDR_COUNTER_RESET = 6'h07;
    localparam logic [5:0] ADDR_COUNT_L       = 6'h08;
    localparam logic [5:0] ADDR_COUNT_H       = 6'h09;
    localparam logic [5:0] ADDR_DIR           = 6'h0A;
    localparam logic [5:0] ADDR_PRESCALE      = 6'h0B;
    localparam logic [5:0] ADDR_PWM_EN        = 6'h0C;
    localparam logic [5:0] ADDR_FUNCTIONS     = 6'h0D;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Replace one byte of a 16-bit register image.
    function automatic logic [CNT_W-1:0] put_byte(input logic [CNT_W-1:0] word,
                                                  input logic             hi,
                                                  input logic [7:0]       b);
        logic [CNT_W-1:0] r;
        r = word;
        if (hi) r[15:8] = b;
        else    r[7:0]  = b;
        return r;
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Prescaler plus up/down period counter; wrap is a registered one-cycle pulse,
// wrap_evt flags the wrapping step combinationally so commits share its edge.
module pwm_counter
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  dir_e             dir,
    input  logic [7:0]       prescale,
    input  logic [CNT_W-1:0] period,
    input  logic             sw_reset,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             wrap_evt
);

    logic [7:0]       pc;
    logic             tick;
    logic             step_wrap;
    logic [CNT_W-1:0] count_next;

    // A count beyond the period (after a DIR flip) wraps on the next tick.
    always_comb begin
        tick       = en && (pc == prescale);
        step_wrap  = 1'b0;
        count_next = count;
        if (dir == DIR_UP) begin
            if (count >= period) begin
                count_next = '0;
                step_wrap  = 1'b1;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end else begin
            if ((count == '0) || (count > period)) begin
                count_next = period;
                step_wrap  = 1'b1;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end
        wrap_evt = tick && step_wrap && !sw_reset;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else if (sw_reset) begin
            pc    <= '0;
            count <= (dir == DIR_DOWN) ? period : '0;
            wrap  <= 1'b1;
        end else begin
            wrap <= tick && step_wrap;
            if (en) begin
                if (tick) begin
                    pc    <= '0;
                    count <= count_next;
                end else begin
                    pc <= pc + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// Register-mapped PWM timer controller: byte register file, double-buffered
// period/compare values committed at period boundaries, and the read mux.
module pwm_timer_ctrl
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [5:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             pwm_en,
    output logic [7:0]       functions,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic [CNT_W-1:0] count_val,
    output logic             wrap
);

    logic [CNT_W-1:0] period_stage;
    logic [CNT_W-1:0] cmp1_stage;
    logic [CNT_W-1:0] cmp2_stage;
    logic             counter_en;
    dir_e             dir;
    logic [7:0]       prescale;
    logic [7:0]       cnt_hi_snap;
    logic [7:0]       rd_mux;
    logic             counter_rst;
    logic             wrap_evt;
    logic             commit;
    logic [CNT_W-1:0] cnt_period;

    assign counter_rst = wr_en && (addr == ADDR_COUNTER_RESET);
    assign commit      = wrap_evt || counter_rst || !counter_en;
    // A software reset in down mode must load the period being committed now.
    assign cnt_period  = counter_rst ? period_stage : period;

    pwm_counter u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (counter_en),
        .dir      (dir),
        .prescale (prescale),
        .period   (cnt_period),
        .sw_reset (counter_rst),
        .count    (count_val),
        .wrap     (wrap),
        .wrap_evt (wrap_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_stage <= '0;
            cmp1_stage   <= '0;
            cmp2_stage   <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_PERIOD_L:   period_stage <= put_byte(period_stage, 1'b0, wdata);
                ADDR_PERIOD_H:   period_stage <= put_byte(period_stage, 1'b1, wdata);
                ADDR_COMPARE1_L: cmp1_stage   <= put_byte(cmp1_stage, 1'b0, wdata);
                ADDR_COMPARE1_H: cmp1_stage   <= put_byte(cmp1_stage, 1'b1, wdata);
                ADDR_COMPARE2_L: cmp2_stage   <= put_byte(cmp2_stage, 1'b0, wdata);
                ADDR_COMPARE2_H: cmp2_stage   <= put_byte(cmp2_stage, 1'b1, wdata);
                default: ;
            endcase
        end
    end

    // Active copies see the pre-edge staging, so a same-cycle write waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period   <= '0;
            compare1 <= '0;
            compare2 <= '0;
        end else if (commit) begin
            period   <= period_stage;
            compare1 <= cmp1_stage;
            compare2 <= cmp2_stage;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_en <= 1'b0;
            dir        <= DIR_UP;
            prescale   <= '0;
            pwm_en     <= 1'b0;
            functions  <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_COUNTER_EN: counter_en <= wdata[0];
                ADDR_DIR:        dir        <= dir_e'(wdata[0]);
                ADDR_PRESCALE:   prescale   <= wdata;
                ADDR_PWM_EN:     pwm_en     <= wdata[0];
                ADDR_FUNCTIONS:  functions  <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            ADDR_PERIOD_L:   rd_mux = period_stage[7:0];
            ADDR_PERIOD_H:   rd_mux = period_stage[15:8];
            ADDR_COUNTER_EN: rd_mux = {7'b0, counter_en};
            ADDR_COMPARE1_L: rd_mux = cmp1_stage[7:0];
            ADDR_COMPARE1_H: rd_mux = cmp1_stage[15:8];
            ADDR_COMPARE2_L: rd_mux = cmp2_stage[7:0];
            ADDR_COMPARE2_H: rd_mux = cmp2_stage[15:8];
            ADDR_COUNT_L:    rd_mux = count_val[7:0];
            ADDR_COUNT_H:    rd_mux = cnt_hi_snap;
            ADDR_DIR:        rd_mux = {7'b0, dir == DIR_DOWN};
            ADDR_PRESCALE:   rd_mux = prescale;
            ADDR_PWM_EN:     rd_mux = {7'b0, pwm_en};
            ADDR_FUNCTIONS:  rd_mux = functions;
            default:         rd_mux = 8'h00;
        endcase
    end

    // Reading the low count byte freezes the high byte for a coherent 16-bit read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata       <= 8'h00;
            cnt_hi_snap <= 8'h00;
        end else if (rd_en) begin
            rdata <= rd_mux;
            if (addr == ADDR_COUNT_L) cnt_hi_snap <= count_val[15:8];
        end
    end

endmodule
